// File: rtl/fp32_addsub_arb_pkg.sv
// Shared constants and types for the arbitrated FP32 add/sub unit.
package fp32_addsub_arb_pkg;

  localparam int FP_W = 32;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic            sub;
  } fp_op_t;

endpackage

// File: rtl/fp32_add.sv
// Combinational FP32 adder/subtractor, round-to-nearest-even.
module fp32_add
  import fp32_addsub_arb_pkg::*;
(
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  input  logic            sub_i,
  output logic [FP_W-1:0] y_o
);

  function automatic logic [4:0] lzc27(
    input logic [26:0] v
  );
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic        sa, sb, sl, ss;
  logic        eff_sub, swap, inc;
  logic        inf_a, inf_b, nan_a, nan_b;
  logic [7:0]  ea, eb, eaf, ebf;
  logic [7:0]  el, es, d, shamt;
  logic [23:0] ma, mb, ml, ms;
  logic [50:0] sh;
  logic [26:0] al, m;
  logic [27:0] s;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic [24:0] mr;

  always_comb begin
    sa    = a_i[31];
    sb    = b_i[31] ^ sub_i;
    ea    = a_i[30:23];
    eb    = b_i[30:23];
    ma    = {|ea, a_i[22:0]};
    mb    = {|eb, b_i[22:0]};
    eaf   = (ea == 8'd0) ? 8'd1 : ea;
    ebf   = (eb == 8'd0) ? 8'd1 : eb;
    inf_a = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
    inf_b = (eb == 8'hFF) && (b_i[22:0] == 23'd0);
    nan_a = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
    nan_b = (eb == 8'hFF) && (b_i[22:0] != 23'd0);

    swap = {ebf, mb} > {eaf, ma};
    sl   = swap ? sb  : sa;
    ss   = swap ? sa  : sb;
    el   = swap ? ebf : eaf;
    es   = swap ? eaf : ebf;
    ml   = swap ? mb  : ma;
    ms   = swap ? ma  : mb;
    eff_sub = sl ^ ss;

    // Smaller operand keeps guard/round bits plus a folded sticky bit.
    d     = el - es;
    sh    = {ms, 27'd0} >> d;
    al    = sh[50:24];
    al[0] = al[0] | (|sh[23:0]);

    s = eff_sub ? ({1'b0, ml, 3'd0} - {1'b0, al})
                : ({1'b0, ml, 3'd0} + {1'b0, al});

    lz    = lzc27(s[26:0]);
    shamt = 8'd0;
    m     = '0;
    e     = '0;
    if (s[27]) begin
      m    = s[27:1];
      m[0] = m[0] | s[0];
      e    = {2'b0, el} + 10'd1;
    end else begin
      shamt = ({3'b0, lz} > (el - 8'd1)) ? (el - 8'd1) : {3'b0, lz};
      m     = s[26:0] << shamt;
      e     = {2'b0, el} - {2'b0, shamt};
    end

    inc = m[2] & (m[3] | m[1] | m[0]);
    mr  = {1'b0, m[26:3]} + {24'd0, inc};
    if (mr[24]) e = e + 10'd1;

    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
      y_o = 32'h7FC0_0000;
    else if (inf_a)
      y_o = {sa, 8'hFF, 23'd0};
    else if (inf_b)
      y_o = {sb, 8'hFF, 23'd0};
    else if (s == 28'd0)
      y_o = {eff_sub ? 1'b0 : sl, 31'd0};
    else if (e >= 10'd255)
      y_o = {sl, 8'hFF, 23'd0};
    else if (mr[24])
      y_o = {sl, e[7:0], 23'd0};
    else
      y_o = {sl, mr[23] ? e[7:0] : 8'd0, mr[22:0]};
  end

endmodule

// File: rtl/fp32_addsub_arb.sv
// N-requester round-robin front end sharing one two-stage FP32 add/sub.
module fp32_addsub_arb
  import fp32_addsub_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*FP_W-1:0] req_a,
  input  logic [N_REQ*FP_W-1:0] req_b,
  input  logic [N_REQ-1:0]      req_sub,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [FP_W-1:0]       res_o,
  output logic [ID_W-1:0]       res_id,
  output logic [31:0]           op_count
);

  fp_op_t          s1_q, op_d;
  logic [ID_W-1:0] id_q, rid_q;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gnt_id;
  logic            v1_q, rv_q;
  logic [FP_W-1:0] res_q, sum;
  logic [31:0]     op_count_q;
  logic            s1_adv, s2_adv;
  logic            gnt_any, take;

  assign s2_adv = !rv_q || res_ready;
  assign s1_adv = !v1_q || s2_adv;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
    take      = gnt_any && s1_adv && rst_n;
    req_ready = take ? (N_REQ'(1) << gnt_id) : '0;
    ptr_d     = ID_W'((int'(gnt_id) + 1) % N_REQ);
    op_d.a    = req_a[int'(gnt_id)*FP_W +: FP_W];
    op_d.b    = req_b[int'(gnt_id)*FP_W +: FP_W];
    op_d.sub  = req_sub[gnt_id];
  end

  fp32_add u_add (
    .a_i   (s1_q.a),
    .b_i   (s1_q.b),
    .sub_i (s1_q.sub),
    .y_o   (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      rv_q       <= 1'b0;
      ptr_q      <= '0;
      op_count_q <= '0;
    end else begin
      if (s2_adv) rv_q <= v1_q;
      if (s1_adv) v1_q <= take;
      if (take) ptr_q <= ptr_d;
      if (rv_q && res_ready)
        op_count_q <= op_count_q + 32'd1;
    end
  end

  // Data registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (s2_adv && v1_q) begin
      res_q <= sum;
      rid_q <= id_q;
    end
    if (take) begin
      s1_q <= op_d;
      id_q <= gnt_id;
    end
  end

  assign res_valid = rv_q;
  assign res_o     = res_q;
  assign res_id    = rid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp32_addsub_arb.sv
// Self-checking bench for fp32_addsub_arb: vectors, corner sequences, random.
module tb_fp32_addsub_arb;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_sub;
  logic [N*32-1:0] req_a, req_b;
  logic           res_valid, res_ready;
  logic [31:0]    res_o, op_count;
  logic [1:0]     res_id;

  int checks = 0;
  int errors = 0;

  fp32_addsub_arb #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_o(res_o), .res_id(res_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic real f2r(logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023),
         f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [24:0] fm;
    logic [28:0] rem;
    int e;
    if (r == 0.0) return 32'd0;
    d   = $realtobits(r);
    e   = int'(d[62:52]) - 1023 + 127;
    fm  = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 ||
        (rem == 29'h1000_0000 && fm[0])) fm = fm + 25'd1;
    if (fm[24]) begin
      fm = fm >> 1;
      e++;
    end
    return {d[63], 8'(e), fm[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(logic [31:0] a,
      logic [31:0] b, logic sub);
    real r;
    r = sub ? f2r(a) - f2r(b) : f2r(a) + f2r(b);
    return r2f(r);
  endfunction

  function automatic int winner(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'(100 + $urandom % 55),
            23'($urandom)};
  endfunction

  task automatic idle();
    req_valid = '0;
    req_sub   = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic single(int id, logic [31:0] a,
      logic [31:0] b, logic sub, logic [31:0] y);
    req_valid = N'(1) << id;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_sub[id] = sub;
    #1 chk("single_ready", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    idle();
    #1 chk("single_lat1", 32'(res_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_res", res_o, y);
    chk("single_id", 32'(res_id), 32'(id));
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] y;
  } vec_t;

  vec_t vt[12];

  typedef struct {
    logic [31:0] y;
    int          id;
    int          edge_n;
  } inflight_t;

  inflight_t q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g, ptr_m, edges;
    logic exp_rv;
    logic [31:0] cnt_m, a, b;
    logic s;

    vt[0]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
    vt[1]  = '{32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000};
    vt[2]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000};
    vt[3]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
    vt[4]  = '{32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000};
    vt[5]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000};
    vt[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
    vt[7]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002};
    vt[8]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
    vt[9]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000};
    vt[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000};
    vt[11] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002};

    res_ready = 1'b1;
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_count", op_count, 32'd0);
    @(negedge clk);

    single(2, vt[0].a, vt[0].b, vt[0].sub, vt[0].y);
    #1 chk("count_one", op_count, 32'd1);
    @(negedge clk);
    for (int i = 1; i < 12; i++)
      single(i % N, vt[i].a, vt[i].b, vt[i].sub, vt[i].y);
    #1 chk("count_tbl", op_count, 32'd12);
    @(negedge clk);

    // All requesters asserted: strict rotation, one result per cycle.
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = 32'h3F800000;
      req_b[i*32 +: 32] = 32'h3F800000;
    end
    for (int c = 0; c < 7; c++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1 << (c % N)));
      if (c >= 2) begin
        chk("rr_valid", 32'(res_valid), 32'd1);
        chk("rr_id", 32'(res_id), 32'((c - 2) % N));
      end
      @(negedge clk);
    end
    idle();

    // Backpressure: two held in flight, then drained in order.
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[63:32] = 32'h3F800000;
    req_b[63:32] = 32'h3F800000;
    #1 chk("bp_ready0", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_a[63:32] = 32'h40400000;
    #1 chk("bp_ready1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_a[63:32] = 32'h40400000;
    req_b[63:32] = 32'h40400000;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_block", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_hold", res_o, 32'h40000000);
      chk("bp_id", 32'(res_id), 32'd1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_resume", 32'(req_ready), 32'h2);
    chk("bp_res0", res_o, 32'h40000000);
    @(negedge clk);
    idle();
    #1 chk("bp_res1", res_o, 32'h40800000);
    @(negedge clk);
    #1 chk("bp_res2", res_o, 32'h40C00000);
    chk("bp_v2", 32'(res_valid), 32'd1);
    @(negedge clk);
    #1 chk("bp_empty", 32'(res_valid), 32'd0);
    chk("bp_count", op_count, 32'd3);
    @(negedge clk);

    // Reset with two operations in flight.
    res_ready = 1'b0;
    req_valid = 4'b0001;
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h3F800000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    #1 chk("rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    chk("rst_mid_v", 32'(res_valid), 32'd0);
    chk("rst_mid_cnt", op_count, 32'd0);
    chk("rst_mid_ptr", 32'(dut.ptr_q), 32'd0);
    chk("rst_mid_rdy", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    idle();
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk("rst_stale", 32'(res_valid), 32'd0);
    end
    @(negedge clk);

    // Counter wrap.
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1 chk("wrap_pre", op_count, 32'hFFFF_FFFF);
    release dut.op_count_q;
    @(negedge clk);
    single(3, vt[1].a, vt[1].b, vt[1].sub, vt[1].y);
    #1 chk("wrap_post", op_count, 32'd0);
    @(negedge clk);

    // Random traffic against the transaction-level model.
    do_reset();
    q.delete();
    ptr_m = 0;
    edges = 0;
    cnt_m = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = N'($urandom);
      res_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        a = rnd_fp();
        b = ($urandom % 8 == 0) ? {a[31:8], 8'($urandom)}
                                : rnd_fp();
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_sub[i] = 1'($urandom);
      end
      #1;
      exp_rv = (q.size() > 0) && (q[0].edge_n + 1 < edges);
      chk("rnd_valid", 32'(res_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rnd_res", res_o, q[0].y);
        chk("rnd_id", 32'(res_id), 32'(q[0].id));
      end
      chk("rnd_count", op_count, cnt_m);
      g = (q.size() < 2 || res_ready)
          ? winner(req_valid, ptr_m) : -1;
      chk("rnd_ready", 32'(req_ready),
          (g >= 0) ? 32'(1 << g) : 32'd0);
      if (exp_rv && res_ready) begin
        void'(q.pop_front());
        cnt_m++;
      end
      if (g >= 0) begin
        s = req_sub[g];
        q.push_back('{ref_add(req_a[g*32 +: 32],
                              req_b[g*32 +: 32], s),
                      g, edges});
        ptr_m = (g + 1) % N;
      end
      edges++;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_addsub_arb.md
FP32_ADDSUB_ARB -- requirements
Module: fp32_addsub_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one FP32 add/sub datapath (legal range 1..16).
REQ-002 SHALL have localparam ID_W = max(1, clog2(N_REQ)), giving the requester-ID width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, N_REQ bits: per-requester operation request.
REQ-006 SHALL have port req_ready, output, N_REQ bits: per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_a, input, N_REQ*32 bits: FP32 operand A; slice i belongs to requester i.
REQ-008 SHALL have port req_b, input, N_REQ*32 bits: FP32 operand B; slice i belongs to requester i.
REQ-009 SHALL have port req_sub, input, N_REQ bits: 1 = A-B, 0 = A+B.
REQ-010 SHALL have port res_valid, output, 1 bit: result available.
REQ-011 SHALL have port res_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port res_o, output, 32 bits: FP32 result.
REQ-013 SHALL have port res_id, output, ID_W bits: index of the requester that issued the result.
REQ-014 SHALL have port op_count, output, 32 bits: count of results delivered.

Function
REQ-015 SHALL implement a two-stage pipeline. S1 is the operand register (a, b, sub, id, v1). S2 is the result register (res_o, res_id, res_valid).
REQ-016 SHALL compute S2 data as the combinational fp32_add of the S1 operands, with sub taken from S1.
REQ-017 A transfer SHALL occur on request i when req_valid[i] and req_ready[i] are both 1 at a rising edge; a result transfer SHALL occur when res_valid and res_ready are both 1.
REQ-018 S2 SHALL advance (s2_adv) when S2 is empty or res_ready=1.
REQ-019 S1 SHALL advance (s1_adv) when S1 is empty or s2_adv=1.
REQ-020 req_ready SHALL be all-zero when s1_adv=0. Otherwise it SHALL be one-hot on the round-robin winner among asserted req_valid bits, and all-zero if none are asserted.
REQ-021 req_ready SHALL be combinational from req_valid, the priority pointer and pipeline occupancy. It SHALL NOT depend on operand data.
REQ-022 Round-robin rule: priority pointer ptr (ID_W bits) is highest priority, descending as ptr, ptr+1, ... mod N_REQ.
REQ-023 After a grant to requester g, ptr SHALL become (g+1) mod N_REQ; with no grant, ptr SHALL be unchanged.
REQ-024 Latency: a request accepted at edge k SHALL show res_valid=1 with its result from edge k+2, provided res_ready was 1 at edge k+1.
REQ-025 Throughput SHALL be one operation per cycle with res_ready held at 1.
REQ-026 Backpressure: with res_valid=1 and res_ready=0, res_o and res_id SHALL stay stable. S1 SHALL hold if occupied. At most 2 operations SHALL be in flight, then req_ready SHALL be all-zero.
REQ-027 Simultaneous events: in one cycle, a result transfer, an S1-to-S2 move and a new accept SHALL all be allowed with no bubble inserted.
REQ-028 Results SHALL leave in acceptance order; res_id SHALL equal the accepted requester index.
REQ-029 op_count SHALL increment by 1 on each result transfer and wrap from 0xFFFFFFFF to 0.
REQ-030 N_REQ=1: requester 0 SHALL be granted whenever s1_adv=1 and req_valid[0]=1, with ptr constant 0.
REQ-031 Requests that are never granted SHALL be allowed to change or drop req_valid without effect. The block SHALL NOT latch any non-granted operand.

Reset
REQ-032 SHALL, on rst_n=0 at a rising edge, clear v1, res_valid, ptr and op_count to 0. Data registers SHALL be unspecified.
REQ-033 SHALL hold req_ready all-zero while rst_n=0.
REQ-034 Reset mid-operation SHALL discard both in-flight operations; no result for them SHALL ever appear.
REQ-035 res_valid SHALL be 0 in the first cycle after reset deassertion.

Structure
REQ-036 The FP32 width constant (32) and the ID_W calculation SHALL live in the shared md-hpc FPGA package; N_REQ SHALL remain a module parameter.
REQ-037 SHALL instantiate exactly one existing fp32_add, with sub driven from the S1 register. The arbiter and pipeline control SHALL be inline.

Verification
REQ-038 Single request: req 2 with a=0x40400000 (3.0), b=0x3F800000 (1.0), sub=1, res_ready=1 -> res_valid 2 cycles after accept, res_o=0x40000000, res_id=2, op_count=1.
REQ-039 All four req_valid held high, res_ready=1 -> grants in order 0,1,2,3,0; one result per cycle; res_id sequence matches.
REQ-040 Backpressure: res_ready=0 after two accepts -> req_ready all-zero, res_o stable. Raise res_ready -> both results in order, then accepts resume the same cycle.
REQ-041 Add: a=0x3FC00000 (1.5), b=0x40200000 (2.5), sub=0 -> res_o=0x40800000 (4.0).
REQ-042 Reset with 2 operations in flight -> res_valid=0, op_count=0, ptr=0; no stale result after release.
REQ-043 Preload op_count to 0xFFFFFFFF via force, deliver one result -> op_count=0.
